// File: rtl/i2c_pkg.sv
// Shared FSM states and constants for the I2C register target.
package i2c_pkg;

    localparam int         SYNC_STAGES = 2;
    localparam logic [6:0] GCALL_ADDR  = 7'b0000000;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WACK,
        RDATA,
        RACK
    } i2c_state_t;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Synchronized I2C bus events passed from the bus synchronizer to the target FSM.
interface i2c_target_regs_if;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    modport master (output scl_rise, scl_fall, start_det, stop_det, sda_s);
    modport slave  (input  scl_rise, scl_fall, start_det, stop_det, sda_s);

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into clk and derives edge, START and STOP events.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scl,
    input  logic               sda,
    i2c_target_regs_if.master  ev
);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign ev.scl_rise  =  scl_s & ~scl_d;
    assign ev.scl_fall  = ~scl_s &  scl_d;
    assign ev.start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign ev.stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;
    assign ev.sda_s     =  sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small byte register file with auto-incrementing pointer.
// Optional general-call write to reg[0] enabled by I2C_TARGET_GCALL_EN.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b0110100,
    parameter int         NUM_REGS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  wr_pulse,
    output logic                  addr_match
);

    localparam int PTR_W = $clog2(NUM_REGS);

    i2c_target_regs_if ev ();

    i2c_bus_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .scl   (scl),
        .sda   (sda),
        .ev    (ev)
    );

    i2c_state_t                 state_q, state_d;
    logic [3:0]                 bit_cnt_q, bit_cnt_d;
    logic [7:0]                 shreg_q, shreg_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d, ptr_inc, ptr_load, widx;
    logic                       sda_oe_q, sda_oe_d;
    logic                       match_q, match_d;
    logic                       gc_q, gc_d;
    logic                       nack_q, nack_d;
    logic                       we;
    logic [NUM_REGS-1:0][7:0]   regs_q;

    assign ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_load = PTR_W'(shreg_q % 8'(NUM_REGS));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        match_d   = match_q;
        gc_d      = gc_q;
        nack_d    = nack_q;
        we        = 1'b0;
        widx      = ptr_q;

        if (ev.stop_det || ev.start_det) begin
            state_d   = ev.start_det ? ADDR : IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            match_d   = 1'b0;
            gc_d      = 1'b0;
        end else if (ev.scl_rise) begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    shreg_d   = {shreg_q[6:0], ev.sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                RDATA:   bit_cnt_d = bit_cnt_q + 4'd1;
                RACK:    nack_d    = ev.sda_s;
                default: ;
            endcase
        end else if (ev.scl_fall) begin
            // Byte-complete decisions happen on the falling edge after bit 8,
            // which is exactly when the ACK slot must start being driven.
            case (state_q)
                ADDR: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    if (shreg_q[7:1] == SLAVE_ADDR) begin
                        state_d  = ADDR_ACK;
                        sda_oe_d = 1'b1;
                        match_d  = 1'b1;
                    end
`ifdef I2C_TARGET_GCALL_EN
                    else if (shreg_q == {GCALL_ADDR, 1'b0}) begin
                        state_d  = ADDR_ACK;
                        sda_oe_d = 1'b1;
                        gc_d     = 1'b1;
                    end
`endif
                    else begin
                        state_d = IDLE;
                    end
                end
                ADDR_ACK: begin
                    bit_cnt_d = '0;
                    if (shreg_q[0]) begin
                        state_d  = RDATA;
                        shreg_d  = regs_q[ptr_q];
                        sda_oe_d = ~regs_q[ptr_q][7];
                    end else begin
                        state_d  = gc_q ? WDATA : PTR;
                        sda_oe_d = 1'b0;
                    end
                end
                PTR: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    ptr_d     = ptr_load;
                    sda_oe_d  = 1'b1;
                    state_d   = PTR_ACK;
                end
                PTR_ACK, WACK: begin
                    sda_oe_d = 1'b0;
                    state_d  = WDATA;
                end
                WDATA: if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    we        = 1'b1;
                    widx      = gc_q ? '0 : ptr_q;
                    if (!gc_q) ptr_d = ptr_inc;
                    sda_oe_d  = 1'b1;
                    state_d   = WACK;
                end
                RDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = RACK;
                    end else begin
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        sda_oe_d = ~shreg_q[6];
                    end
                end
                RACK: begin
                    bit_cnt_d = '0;
                    if (nack_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        ptr_d    = ptr_inc;
                        shreg_d  = regs_q[ptr_inc];
                        sda_oe_d = ~regs_q[ptr_inc][7];
                        state_d  = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            match_q   <= 1'b0;
            gc_q      <= 1'b0;
            nack_q    <= 1'b0;
            wr_pulse  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            match_q   <= match_d;
            gc_q      <= gc_d;
            nack_q    <= nack_d;
            wr_pulse  <= we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  regs_q       <= '0;
        else if (we) regs_q[widx] <= shreg_q;
    end

    assign reg_out    = regs_q;
    assign addr_match = match_q;
    assign sda        = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs with a queue-based scoreboard.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mon_rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    logic [31:0] reg_out;
    logic        wr_pulse;
    logic        addr_match;

    int n_tests = 0, n_fail = 0;
    int wr_cnt = 0, low_cnt = 0, n_start_seen = 0, n_start = 0;
    int exp_q[$];

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_target_regs #(.SLAVE_ADDR(7'b0110100), .NUM_REGS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl        (scl),
        .sda        (sda),
        .reg_out    (reg_out),
        .wr_pulse   (wr_pulse),
        .addr_match (addr_match)
    );

    // Independent bus monitor: counts STARTs seen on the wire.
    i2c_target_regs_if mon_if ();
    i2c_bus_sync u_mon (
        .clk   (clk),
        .rst_n (mon_rst_n),
        .scl   (scl),
        .sda   (sda),
        .ev    (mon_if)
    );

    always @(negedge clk) begin
        if (wr_pulse) wr_cnt++;
        if (mon_if.start_det) n_start_seen++;
        if (sda == 1'b0 && !m_low) low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (!scl) begin
            m_low = 1'b0; tick(Q);
            scl   = 1'b1; tick(Q);
        end
        m_low = 1'b1; tick(Q);
        scl   = 1'b0; tick(Q);
        n_start++;
    endtask

    task automatic bus_stop();
        m_low = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        m_low = 1'b0; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b;   tick(Q);
        scl   = 1'b1; tick(2*Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        b     = sda;  tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic exp_ack);
        logic a;
        exp_q.push_back(int'(exp_ack));
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        chk($sformatf("ack_%02h", d), 32'(a), 32'(exp_q.pop_front()));
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic ack);
        logic [7:0] d;
        logic       b;
        exp_q.push_back(int'(exp));
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack ? 1'b0 : 1'b1);
        chk("rd_data", 32'(d), 32'(exp_q.pop_front()));
    endtask

    initial begin
        int  w0, l0;
        logic b;

        tick(2);
        mon_rst_n = 1'b1;

        // bus traffic while held in reset is ignored
        bus_start();
        wr_byte(8'h68, 1'b1);
        bus_stop();
        chk("rst_regs", reg_out, 32'h0);
        chk("rst_match", 32'(addr_match), 32'h0);
        chk("rst_wrp", 32'(wr_pulse), 32'h0);
        chk("rst_state", 32'(int'(dut.state_q)), 32'(int'(IDLE)));
        chk("rst_sda_low", 32'(low_cnt), 32'h0);
        rst_n = 1'b1;
        tick(4);

        // single write
        w0 = wr_cnt;
        bus_start();
        wr_byte(8'h68, 1'b0);
        chk("match_hi", 32'(addr_match), 32'h1);
        wr_byte(8'h01, 1'b0);
        wr_byte(8'hAA, 1'b0);
        bus_stop();
        chk("wr_regs", reg_out, 32'h0000AA00);
        chk("wr_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("match_lo", 32'(addr_match), 32'h0);

        // pointer write, repeated START, single read with NACK
        bus_start();
        wr_byte(8'h68, 1'b0);
        wr_byte(8'h01, 1'b0);
        bus_start();
        wr_byte(8'h69, 1'b0);
        rd_byte(8'hAA, 1'b0);
        bus_stop();
        chk("rd_idle", 32'(int'(dut.state_q)), 32'(int'(IDLE)));

        // write wraps pointer 3 -> 0
        w0 = wr_cnt;
        bus_start();
        wr_byte(8'h68, 1'b0);
        wr_byte(8'h03, 1'b0);
        wr_byte(8'h11, 1'b0);
        wr_byte(8'h22, 1'b0);
        bus_stop();
        chk("wrap_regs", reg_out, 32'h1100AA22);
        chk("wrap_pulses", 32'(wr_cnt - w0), 32'd2);

        // burst read wraps pointer 3 -> 0 -> 1
        bus_start();
        wr_byte(8'h68, 1'b0);
        wr_byte(8'h03, 1'b0);
        bus_start();
        wr_byte(8'h69, 1'b0);
        rd_byte(8'h11, 1'b1);
        rd_byte(8'h22, 1'b1);
        rd_byte(8'hAA, 1'b0);
        bus_stop();

        // address mismatch
        l0 = low_cnt;
        bus_start();
        wr_byte(8'h6A, 1'b1);
        chk("mis_match", 32'(addr_match), 32'h0);
        wr_byte(8'h55, 1'b1);
        bus_stop();
        chk("mis_sda", 32'(low_cnt - l0), 32'h0);
        chk("mis_regs", reg_out, 32'h1100AA22);

        // partial bytes cut by STOP and by repeated START
        w0 = wr_cnt;
        bus_start();
        wr_byte(8'h68, 1'b0);
        wr_byte(8'h02, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        bus_start();
        wr_byte(8'h68, 1'b0);
        wr_byte(8'h02, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        bus_start();
        wr_byte(8'h68, 1'b0);
        bus_stop();
        chk("part_regs", reg_out, 32'h1100AA22);
        chk("part_pulses", 32'(wr_cnt - w0), 32'd0);

        // general call
        bus_start();
`ifdef I2C_TARGET_GCALL_EN
        wr_byte(8'h00, 1'b0);
        chk("gc_match", 32'(addr_match), 32'h0);
        wr_byte(8'h5C, 1'b0);
        bus_stop();
        chk("gc_regs", reg_out, 32'h1100AA5C);
`else
        wr_byte(8'h00, 1'b1);
        bus_stop();
        chk("gc_regs", reg_out, 32'h1100AA22);
`endif

        // reset while the target drives a read data bit
        bus_start();
        wr_byte(8'h68, 1'b0);
        wr_byte(8'h03, 1'b0);
        bus_start();
        wr_byte(8'h69, 1'b0);
        m_low = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        chk("rd_bit7_low", 32'(sda), 32'h0);
        rst_n = 1'b0;
        tick(1);
        chk("rstmid_sda", 32'(sda), 32'h1);
        chk("rstmid_regs", reg_out, 32'h0);
        chk("rstmid_match", 32'(addr_match), 32'h0);
        tick(2);
        rst_n = 1'b1;
        l0 = low_cnt;
        tick(Q);
        scl = 1'b0; tick(Q);
        for (int i = 0; i < 8; i++) recv_bit(b);
        chk("rstmid_drop", 32'(low_cnt - l0), 32'h0);
        bus_stop();
        chk("rstmid_idle", 32'(int'(dut.state_q)), 32'(int'(IDLE)));

        // recovers on the next START
        bus_start();
        wr_byte(8'h68, 1'b0);
        wr_byte(8'h00, 1'b0);
        wr_byte(8'h77, 1'b0);
        bus_stop();
        chk("post_rst_regs", reg_out, 32'h00000077);

        tick(4);
        chk("mon_starts", 32'(n_start_seen), 32'(n_start));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b0110100: 7-bit address this target answers to.
REQ-002 SHALL have parameter NUM_REGS, default 4: register file depth, range 2..16.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port scl, input, 1: I2C clock from the master; the target never drives it.
REQ-006 SHALL have port sda, inout, 1: open-drain data line; driven 1'b0 or left high-impedance, never driven 1'b1.
REQ-007 SHALL have port reg_out, output, 8*NUM_REGS: flat view of the register file; register k is bits [8k+7:8k].
REQ-008 SHALL have port wr_pulse, output, 1: one-clk strobe after each data byte is written into the register file.
REQ-009 SHALL have port addr_match, output, 1: high from the address ACK until the next STOP or START.

Function
REQ-010 SHALL pass scl and sda through 2-flop synchronizers, then a third flop used for edge detection.
REQ-011 SHALL detect START as synchronized sda falling while scl is high, and STOP as sda rising while scl is high.
REQ-012 SHALL sample data bits on the synchronized scl rising edge, MSB first.
REQ-013 SHALL change its sda drive only on the synchronized scl falling edge.
REQ-014 SHALL implement FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK.
REQ-015 SHALL, on START from any state (repeated START included), enter ADDR and clear the bit counter.
REQ-016 SHALL, on STOP from any state, release sda and enter IDLE.
REQ-017 SHALL, in ADDR after 8 bits, enter ADDR_ACK only if bits [7:1] equal SLAVE_ADDR; on mismatch it enters IDLE and does not drive sda.
REQ-018 SHALL, in ADDR_ACK, pull sda low for one SCL period, then:
  - enter PTR if R/W is 0;
  - enter RDATA if R/W is 1.
REQ-019 SHALL, in PTR, load the byte as the register pointer modulo NUM_REGS, ACK it, then enter WDATA.
REQ-020 SHALL, in WDATA, write each byte to reg[ptr], assert wr_pulse for one clk, ACK the byte, and increment ptr.
REQ-021 SHALL, in RDATA, shift out reg[ptr] MSB first, releasing sda for 1-bits; in RACK it samples the master's bit.
  - ACK (0): increment ptr and return to RDATA.
  - NACK (1): release sda and enter IDLE.
REQ-022 SHALL wrap the pointer from NUM_REGS-1 to 0, for both reads and writes.
REQ-023 SHALL keep the pointer across a repeated START, so a write-pointer then repeated-START read returns reg[ptr].
REQ-024 SHALL not write the register file from a partial byte interrupted by START or STOP.

Reset
REQ-025 SHALL, while rst_n is low, hold the following, regardless of bus activity:
  - FSM in IDLE;
  - sda released;
  - reg_out all zero;
  - ptr = 0;
  - wr_pulse = 0;
  - addr_match = 0.
REQ-026 SHALL, after release, ignore the bus until it sees a START; a transfer already in progress is dropped.

Configuration
REQ-027 SHALL support macro I2C_TARGET_GCALL_EN.
  - Defined: address 7'b0000000 with R/W=0 is ACKed; the next byte is ACKed and written to reg[0]; addr_match stays low.
  - Undefined: the general-call address is NACKed like any other mismatch.

Structure
REQ-028 SHALL place the FSM state enum, the general-call address constant and the synchronizer depth in the shared package i2c_pkg.
REQ-029 SHALL implement START/STOP/edge detection as sub-module i2c_bus_sync, with outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

Verification
REQ-030 SHALL verify single write: master writes 0x68, 0x01, 0xAA -> three ACKs, reg[1]=0xAA, one wr_pulse.
REQ-031 SHALL verify read with repeated START: write 0x68, 0x01; repeated START; 0x69; read one byte with NACK -> 0xAA returned, FSM in IDLE after STOP.
REQ-032 SHALL verify pointer wrap: write 0x68, 0x03, 0x11, 0x22 -> reg[3]=0x11, reg[0]=0x22.
REQ-033 SHALL verify address mismatch: address 0x6A -> sda never driven low, ack_error=1 at the master, registers unchanged.
REQ-034 SHALL verify reset mid-transfer: rst_n low during a data byte -> sda released within 1 clk, all registers 0x00.
REQ-035 SHALL verify general call with I2C_TARGET_GCALL_EN defined: 0x00, 0x5C -> both ACKed, reg[0]=0x5C; without the macro, the first byte is NACKed.
